// File: rtl/serializer_ddr_if.sv
// Handshake and DDR output bundle for serializer_ddr.
// Word width and lane count must match the serializer_ddr instance.
interface serializer_ddr_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
);
  logic                      oe;
  logic                      in_valid;
  logic [LANES*DATA_W-1:0]   in_data;
  logic                      in_ready;
  logic                      txclk_en;
  logic [LANES-1:0]          tx_rise;
  logic [LANES-1:0]          tx_fall;
  logic                      busy;

  modport master (
    output oe, in_valid, in_data,
    input  in_ready, txclk_en, tx_rise, tx_fall, busy
  );

  modport slave (
    input  oe, in_valid, in_data,
    output in_ready, txclk_en, tx_rise, tx_fall, busy
  );
endinterface

// File: rtl/serializer_ddr.sv
// Multi-lane DDR serializer: sync pair, then MSB-first bit pairs per lane, all outputs registered.
// Define SERIALIZER_PARITY_EN to append one even-parity pair to every frame.
//
// state  | meaning
// INIT   | outputs low, wait counter cleared, leaves once oe is high
// WAIT   | forwarded clock running for WAIT_LEN cycles before data
// IDLE   | clock running, pairs 00, ready for a word
// SYNC   | every lane drives (1,0)
// SEND   | data beats, two bits per lane per cycle
// PARITY | (macro only) each lane drives (^word,0)
module serializer_ddr #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 1,
  parameter int WAIT_LEN = 100
) (
  input  logic             clk,
  input  logic             reset,
  serializer_ddr_if.slave  bus
);

  localparam int BEATS  = DATA_W / 2;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = $clog2(WAIT_LEN + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LEN - 1);

  if (DATA_W < 2 || (DATA_W % 2) != 0) begin : g_bad_data_w
    $error("serializer_ddr: DATA_W must be even and >= 2");
  end
  if (WAIT_LEN < 1) begin : g_bad_wait_len
    $error("serializer_ddr: WAIT_LEN must be >= 1");
  end

  typedef enum logic [2:0] {
    S_INIT,
    S_WAIT,
    S_IDLE,
    S_SYNC,
    S_SEND
`ifdef SERIALIZER_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t                        state_q, state_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [WAIT_W-1:0]             wait_q, wait_d;
  logic [LANES-1:0][DATA_W-1:0]  sh_q, sh_d;
`ifdef SERIALIZER_PARITY_EN
  logic [LANES-1:0]              par_q, par_d;
`endif
  logic                          in_ready_q, in_ready_d;
  logic                          txclk_en_q, txclk_en_d;
  logic                          busy_q, busy_d;
  logic [LANES-1:0]              rise_q, rise_d;
  logic [LANES-1:0]              fall_q, fall_d;
  logic                          accept;
  logic                          frame_end;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    sh_d       = sh_q;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif
    in_ready_d = 1'b0;
    txclk_en_d = 1'b1;
    busy_d     = 1'b0;
    rise_d     = '0;
    fall_d     = '0;

    // in_ready_q is high exactly in IDLE and at the frame boundary
    accept = bus.in_valid && in_ready_q;
`ifdef SERIALIZER_PARITY_EN
    frame_end = (state_q == S_PARITY);
`else
    frame_end = (state_q == S_SEND) && (beat_q == LAST_BEAT);
`endif

    if (state_q == S_IDLE || frame_end) begin
      if (accept) begin
        state_d = S_SYNC;
        sh_d    = bus.in_data;
`ifdef SERIALIZER_PARITY_EN
        for (int k = 0; k < LANES; k++) begin
          par_d[k] = ^bus.in_data[k*DATA_W +: DATA_W];
        end
`endif
        busy_d  = 1'b1;
        rise_d  = '1;
      end else begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_INIT: begin
          wait_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_d    = S_IDLE;
            wait_d     = '0;
            in_ready_d = 1'b1;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_SYNC, S_SEND: begin
          busy_d = 1'b1;
`ifdef SERIALIZER_PARITY_EN
          if (state_q == S_SEND && beat_q == LAST_BEAT) begin
            state_d    = S_PARITY;
            rise_d     = par_q;
            in_ready_d = 1'b1;
          end else begin
`else
          begin
`endif
            state_d = S_SEND;
            beat_d  = (state_q == S_SYNC) ? '0 : beat_q + 1'b1;
            for (int k = 0; k < LANES; k++) begin
              rise_d[k] = sh_q[k][DATA_W-1];
              fall_d[k] = sh_q[k][DATA_W-2];
              sh_d[k]   = sh_q[k] << 2;
            end
`ifndef SERIALIZER_PARITY_EN
            if (beat_d == LAST_BEAT) in_ready_d = 1'b1;
`endif
          end
        end
        default: state_d = S_INIT;
      endcase
    end

    // oe low aborts everything, including a frame in flight
    if (!bus.oe) begin
      state_d    = S_INIT;
      wait_d     = '0;
      in_ready_d = 1'b0;
      txclk_en_d = 1'b0;
      busy_d     = 1'b0;
      rise_d     = '0;
      fall_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      beat_q     <= '0;
      wait_q     <= '0;
      sh_q       <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= '0;
`endif
      in_ready_q <= 1'b0;
      txclk_en_q <= 1'b0;
      busy_q     <= 1'b0;
      rise_q     <= '0;
      fall_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      sh_q       <= sh_d;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
      in_ready_q <= in_ready_d;
      txclk_en_q <= txclk_en_d;
      busy_q     <= busy_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.txclk_en = txclk_en_q;
  assign bus.busy     = busy_q;
  assign bus.tx_rise  = rise_q;
  assign bus.tx_fall  = fall_q;

endmodule

// File: doc/serializer_ddr.md
# serializer_ddr

Parametrised multi-lane DDR serializer. It replaces the single-lane, 8-bit, clock-muxed serializer with a fully registered design. Each lane takes one DATA_W-bit word per frame through a valid/ready handshake. Each frame is a sync symbol followed by the data, MSB first, as rising/falling bit pairs. The block sits between the sample packer and the FPGA DDR output primitives (ODDR/ALTDDIO_OUT), which drive the LVDS data and clock pins.

## Interface
- DATA_W, 8: bits per lane per frame; must be even and ≥2, otherwise an elaboration error.
- LANES, 1: number of parallel data lanes sharing one frame clock.
- WAIT_LEN, 100: idle cycles with the clock running before the first frame; ≥1.
- clk  in  1  single system clock; also the LVDS bit-pair rate.
- reset  in  1  asynchronous, active-high reset.
- oe  in  1  output enable; low forces the block back to INIT.
- in_valid  in  1  in_data holds a word for every lane.
- in_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- in_ready  out  1  block accepts a word this cycle.
- txclk_en  out  1  enables the forwarded LVDS clock (ODDR 1/0 pattern).
- tx_rise  out  LANES  bit driven on the rising-edge half per lane.
- tx_fall  out  LANES  bit driven on the falling-edge half per lane.
- busy  out  1  high in SYNC, SEND and PARITY.

## Operation
- States: INIT, WAIT, IDLE, SYNC, SEND, PARITY (PARITY exists only with the macro).
- INIT: all outputs 0 and wait counter cleared. If oe=1, the next state is WAIT.
- WAIT: txclk_en=1 and tx pairs 00. After exactly WAIT_LEN cycles in WAIT, go to IDLE. The counter is $clog2(WAIT_LEN+1) bits wide.
- IDLE: in_ready=1 and tx pairs 00 with the clock running. Accept on in_valid&in_ready, load the shift register, go to SYNC.
- SYNC: every lane drives (rise,fall)=(1,0). Next state is SEND with beat counter 0.
- SEND beat b (0..DATA_W/2-1): lane drives (word[DATA_W-1-2b], word[DATA_W-2-2b]).
  - After the last beat: go to PARITY (macro on), otherwise to the frame boundary.
- Frame boundary = last SEND beat (macro off) or the PARITY cycle (macro on). in_ready=1 in that cycle.
  - If a word is accepted there, the next state is SYNC with no gap (back-to-back).
  - If no word is accepted, go to IDLE.
- in_ready is a function of state only. It never depends on in_valid.
- in_data is captured only on acceptance. Later changes to in_data do not affect a frame in flight.
- oe=0 sampled in any state: next state INIT, and all outputs return to their reset values at that edge. A frame in flight is aborted with no completion.

## Timing
- All outputs are registered. Reset value of every output is 0, applied asynchronously.
- Accept at edge N: the SYNC pair is visible after edge N, then data beats after edges N+1 .. N+DATA_W/2.
- Frame period: 1+DATA_W/2 cycles (macro off), or 2+DATA_W/2 cycles (macro on). Sustained throughput is one word per lane per frame.
- First in_ready after reset release with oe=1: 1 cycle in INIT, then WAIT_LEN cycles in WAIT, then IDLE.
- txclk_en is high from entry into WAIT until INIT is re-entered.
- Reset asserted mid-frame: outputs go to 0 immediately, the state goes to INIT, and the full WAIT sequence repeats after release.
- Reset and oe=0 together: same as reset alone.

## Configuration
- SERIALIZER_PARITY_EN defined: one PARITY cycle follows SEND in every frame.
  - Each lane drives (rise,fall)=(^word,0), i.e. even parity over that lane's DATA_W bits.
  - Frame period becomes 2+DATA_W/2 cycles.
- SERIALIZER_PARITY_EN undefined: no PARITY state and no parity logic. The frame ends at the last SEND beat.

## Test plan
Unless noted: DATA_W=8, LANES=2, WAIT_LEN=4, macro off.
- Reset release with oe=1 → txclk_en rises after 1 cycle, in_ready first goes high after 4 further cycles, all tx pairs 00 throughout.
- Single word, lane0=0xA5 and lane1=0x3C:
  - Both lanes show sync (1,0).
  - Lane0 then shows (1,0),(1,0),(0,1),(0,1).
  - Lane1 then shows (0,0),(1,1),(1,1),(0,0).
  - busy is high for exactly 5 cycles.
- in_valid held high with 0xFF then 0x00 on both lanes → two contiguous 5-cycle frames with no 00 gap. in_ready is high once per frame, in the last data beat.
- in_valid low after WAIT → in_ready stays 1, txclk_en stays 1, pairs stay 00, busy stays 0.
- Reset asserted during beat 1 of a frame → all outputs 0 before the next clk edge, and the 4-cycle WAIT repeats after release. oe dropped mid-frame → INIT and txclk_en=0 at the next edge.
- Macro on, lane0=0x07 → sync, four data beats, then PARITY pair (1,0). Frame period 6 cycles.
